// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver with mid-bit oversampled sampling and a link
// watchdog that clears the motion bits of the control word on silence.
module uart_cmd_rx #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVS        = 16,
  parameter int unsigned TIMEOUT_MS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] control_out,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       link_lost
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * OVS);
  localparam int unsigned DW    = $clog2(DIV + 1);
  localparam int unsigned TW    = $clog2(OVS);
  localparam int unsigned LIMIT = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned WD_W  = $clog2(LIMIT) + 1;

  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0]   T_FULL   = TW'(OVS - 1);
  localparam logic [TW-1:0]   T_HALF   = TW'(OVS / 2 - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(LIMIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [DW-1:0]   div_q, div_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      control_q, control_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            link_lost_q, link_lost_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic rx_s;
  logic tick;
  logic wd_expired;

  assign rx_s       = sync_q[1];
  assign tick       = (div_q == DIV_LAST);
  assign wd_expired = (wd_q == WD_LIMIT);

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], serial};
    div_d       = tick ? '0 : div_q + DW'(1);
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    control_d   = control_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    link_lost_d = link_lost_q;
    wd_d        = wd_expired ? wd_q : wd_q + WD_W'(1);

    if (wd_expired) begin
      link_lost_d    = 1'b1;
      control_d[7:4] = '0;
    end

    // An accepted byte in STOP overrides the watchdog assignments above.
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          div_d      = '0;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == T_HALF) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == T_FULL) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_d = STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == T_FULL) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              control_d   = shift_q;
              cmd_valid_d = 1'b1;
              wd_d        = '0;
              link_lost_d = 1'b0;
              state_d     = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        if (!rx_s) begin
          tick_cnt_d = '0;
        end else if (tick) begin
          if (tick_cnt_q == T_FULL) state_d = IDLE;
          else                      tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      control_q   <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      link_lost_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      control_q   <= control_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      link_lost_q <= link_lost_d;
      wd_q        <= wd_d;
    end
  end

  assign control_out = control_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_err   = frame_err_q;
  assign link_lost   = link_lost_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: scaled clock/baud, frame-level reference model
// tracking the last accepted byte and the time since it was accepted.
module tb_uart_cmd_rx;

  localparam int unsigned CLK_HZ     = 1_600_000;
  localparam int unsigned BAUD       = 10_000;
  localparam int unsigned OVS        = 16;
  localparam int unsigned TIMEOUT_MS = 4;
  localparam int BIT    = CLK_HZ / BAUD;             // 160 clocks per bit
  localparam int LIMIT  = CLK_HZ / 1000 * TIMEOUT_MS; // 6400 clocks
  localparam int MARGIN = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;
  logic [7:0] control_out;
  logic       cmd_valid;
  logic       frame_err;
  logic       link_lost;

  uart_cmd_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVS       (OVS),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial     (serial),
    .control_out(control_out),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err),
    .link_lost  (link_lost)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int valid_cyc = 0;
  logic [7:0] last_val = '0;

  // Reference model state
  logic [7:0] exp_byte = '0;
  int         last_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid || frame_err) check_eq("excl", 32'(cmd_valid & frame_err), 32'd0);
      if (cmd_valid) begin
        n_valid++;
        last_val  = control_out;
        valid_cyc = cyc;
      end
      if (frame_err) n_ferr++;
    end
  end

  // Compare outputs with the model unless too close to the timeout edge.
  task automatic check_state(input string tag);
    int age;
    logic [7:0] ec;
    age = cyc - last_acc;
    if (age > LIMIT - MARGIN && age < LIMIT + MARGIN) return;
    ec = (age >= LIMIT) ? {4'h0, exp_byte[3:0]} : exp_byte;
    check_eq({tag, "_ctrl"}, 32'(control_out), 32'(ec));
    check_eq({tag, "_lost"}, 32'(link_lost), 32'(age >= LIMIT));
  endtask

  task automatic drive_bit(input logic v);
    serial = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Caller must be at a negedge; returns at a negedge after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic good_stop);
    int v0, f0, t0, ts;
    v0 = n_valid;
    f0 = n_ferr;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    ts = cyc;
    drive_bit(good_stop);
    if (good_stop) begin
      check_eq("valid_cnt", 32'(n_valid - v0), 32'd1);
      check_eq("ferr_cnt", 32'(n_ferr - f0), 32'd0);
      check_eq("rx_byte", 32'(last_val), 32'(b));
      check_eq("latency", 32'((valid_cyc - t0) >= 9 * BIT + BIT / 2 - 10 &&
                              (valid_cyc - t0) <= 9 * BIT + BIT / 2 + 30), 32'd1);
      exp_byte = b;
      last_acc = ts + BIT / 2 + 4;
    end else begin
      check_eq("bad_valid_cnt", 32'(n_valid - v0), 32'd0);
      check_eq("bad_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    end
  endtask

  initial begin
    int v0, f0;
    logic [7:0] rb;
    int kind;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    last_acc = cyc;
    exp_byte = '0;
    idle(1000);
    check_eq("rst_ctrl", 32'(control_out), 32'h00);
    check_eq("rst_lost", 32'(link_lost), 32'd0);
    check_eq("rst_pulses", 32'(n_valid + n_ferr), 32'd0);

    send_frame(8'hA5, 1'b1);
    idle(100);
    check_state("a5");

    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(50);
    check_eq("b2b_ctrl", 32'(control_out), 32'hC3);

    v0 = n_valid; f0 = n_ferr;
    serial = 1'b0;
    repeat (3) @(negedge clk);
    idle(2 * BIT);
    check_eq("glitch_pulses", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
    check_state("glitch");

    send_frame(8'h77, 1'b1);
    f0 = n_ferr;
    send_frame(8'h6E, 1'b0);
    serial = 1'b0;
    repeat (1600) @(negedge clk);
    check_state("break_mid");
    repeat (1600) @(negedge clk);
    check_eq("break_ferr", 32'(n_ferr - f0), 32'd1);
    check_state("break_end");
    idle(2 * BIT);
    send_frame(8'h21, 1'b1);
    check_eq("after_break", 32'(control_out), 32'h21);

    send_frame(8'h2E, 1'b1);
    idle(LIMIT + LIMIT / 10);
    check_eq("wd_lost", 32'(link_lost), 32'd1);
    check_eq("wd_ctrl", 32'(control_out), 32'h0E);
    check_state("wd");
    send_frame(8'h1E, 1'b1);
    check_eq("wd_rec_lost", 32'(link_lost), 32'd0);
    check_eq("wd_rec_ctrl", 32'(control_out), 32'h1E);

    send_frame(8'hFF, 1'b1);
    idle(20);
    check_eq("ff_ctrl", 32'(control_out), 32'hFF);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ctrl", 32'(control_out), 32'h00);
    check_eq("async_rst_valid", 32'(cmd_valid), 32'd0);
    serial = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    last_acc = cyc;
    exp_byte = '0;
    idle(2 * BIT);
    check_state("post_rst");
    send_frame(8'h12, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        v0 = n_valid; f0 = n_ferr;
        serial = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        idle(2 * BIT);
        check_eq("rnd_glitch", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
      end else if (kind == 1) begin
        send_frame(rb, 1'b0);
        serial = 1'b0;
        repeat ($urandom_range(0, 200)) @(negedge clk);
        idle(BIT + 20);
      end else begin
        send_frame(rb, 1'b1);
      end
      idle($urandom_range(0, 400));
      check_state("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
